// File: rtl/cnn_layer_accel_pixel_ingest.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_pixel_ingest
// Accepts a stream of pixel beats for one CNN layer job and writes them into a
// ring of row buffers. It tracks how many committed rows are held and tells
// the consumer when enough rows exist for one kernel window.
//
// Ports
//   clk, rst            core clock, synchronous active-high reset
//   cfg_*               job configuration, taken in IDLE when cfg_valid and
//                       every field is in range
//   pixel_valid/ready   input beat handshake, pixel_data carries 8 pixels
//   buf_wr_*            row-buffer write port, one cycle after acceptance
//   row_release         consumer frees the oldest committed row
//   rows_avail          committed rows currently held in the ring
//   window_ready        rows_avail covers the kernel height
//   release_err         sticky, release requested with nothing held
//   busy, done          job in progress, one-cycle completion pulse
// ---------------------------------------------------------------------------
module cnn_layer_accel_pixel_ingest #(
    parameter int C_PIXEL_WIDTH = 16,
    parameter int C_BEAT_WIDTH  = 128,
    parameter int C_RING_ROWS   = 4,
    parameter int C_MAX_BEATS   = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_valid,
    input  logic [6:0]                       cfg_row_beats,
    input  logic [9:0]                       cfg_num_rows,
    input  logic [3:0]                       cfg_kernel_size,
    input  logic                             pixel_valid,
    output logic                             pixel_ready,
    input  logic [C_BEAT_WIDTH-1:0]          pixel_data,
    output logic                             buf_wr_en,
    output logic [$clog2(C_RING_ROWS)-1:0]   buf_wr_row,
    output logic [$clog2(C_MAX_BEATS)-1:0]   buf_wr_col,
    output logic [C_BEAT_WIDTH-1:0]          buf_wr_data,
    input  logic                             row_release,
    output logic [$clog2(C_RING_ROWS):0]     rows_avail,
    output logic                             window_ready,
    output logic                             release_err,
    output logic                             busy,
    output logic                             done
);

    localparam int C_ROW_W   = $clog2(C_RING_ROWS);
    localparam int C_COL_W   = $clog2(C_MAX_BEATS);
    localparam int C_AVAIL_W = C_ROW_W + 1;
    localparam int C_PIXELS  = C_BEAT_WIDTH / C_PIXEL_WIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]              r_state;
    logic [6:0]              r_row_beats;
    logic [9:0]              r_num_rows;
    logic [3:0]              r_kernel;
    logic [C_COL_W-1:0]      r_col;
    logic [C_ROW_W-1:0]      r_wr_row;
    logic [9:0]              r_rows_written;
    logic [C_AVAIL_W-1:0]    r_rows_avail;
    logic                    r_pixel_ready;
    logic                    r_window_ready;
    logic                    r_release_err;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_buf_wr_en;
    logic [C_ROW_W-1:0]      r_buf_wr_row;
    logic [C_COL_W-1:0]      r_buf_wr_col;
    logic [C_BEAT_WIDTH-1:0] r_buf_wr_data;

    logic                    w_cfg_ok;
    logic                    w_cfg_take;
    logic                    w_accept;
    logic                    w_col_last;
    logic                    w_commit;
    logic                    w_last_row;
    logic                    w_rel_ok;
    logic                    w_rel_bad;
    logic [1:0]              w_state_nxt;
    logic [C_AVAIL_W-1:0]    w_rows_avail_nxt;
    logic [3:0]              w_kernel_nxt;

    assign w_cfg_ok   = (cfg_row_beats != 7'd0)
                     && (32'(cfg_row_beats) <= 32'(C_MAX_BEATS))
                     && (cfg_num_rows != 10'd0)
                     && (cfg_kernel_size != 4'd0)
                     && (32'(cfg_kernel_size) <= 32'(C_RING_ROWS));
    assign w_cfg_take = (r_state == S_IDLE) && cfg_valid && w_cfg_ok;
    // r_pixel_ready is only ever set in FILL, so the handshake alone is enough.
    assign w_accept   = pixel_valid && r_pixel_ready;
    assign w_col_last = (32'(r_col) == (32'(r_row_beats) - 32'd1));
    assign w_commit   = w_accept && w_col_last;
    assign w_last_row = w_commit && (r_rows_written == (r_num_rows - 10'd1));
    assign w_rel_ok   = row_release && (r_rows_avail != {C_AVAIL_W{1'b0}});
    assign w_rel_bad  = row_release && (r_rows_avail == {C_AVAIL_W{1'b0}});
    assign w_kernel_nxt = w_cfg_take ? cfg_kernel_size : r_kernel;

    // Occupancy next value: a commit and a release in the same cycle cancel.
    always_comb begin
        w_rows_avail_nxt = r_rows_avail;
        if (w_cfg_take) begin
            w_rows_avail_nxt = {C_AVAIL_W{1'b0}};
        end else if (w_commit && !w_rel_ok) begin
            w_rows_avail_nxt = r_rows_avail + C_AVAIL_W'(1'b1);
        end else if (!w_commit && w_rel_ok) begin
            w_rows_avail_nxt = r_rows_avail - C_AVAIL_W'(1'b1);
        end else begin
            w_rows_avail_nxt = r_rows_avail;
        end
    end

    // Job FSM next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = w_cfg_take ? S_FILL : S_IDLE;
            S_FILL:  w_state_nxt = w_last_row ? S_DRAIN : S_FILL;
            S_DRAIN: w_state_nxt = (w_rows_avail_nxt == {C_AVAIL_W{1'b0}}) ? S_DONE : S_DRAIN;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, job configuration and ring bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_row_beats    <= 7'd0;
            r_num_rows     <= 10'd0;
            r_kernel       <= 4'd0;
            r_col          <= {C_COL_W{1'b0}};
            r_wr_row       <= {C_ROW_W{1'b0}};
            r_rows_written <= 10'd0;
            r_rows_avail   <= {C_AVAIL_W{1'b0}};
            r_release_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rows_avail <= w_rows_avail_nxt;
            if (w_rel_bad) begin
                r_release_err <= 1'b1;
            end
            if (w_cfg_take) begin
                r_row_beats    <= cfg_row_beats;
                r_num_rows     <= cfg_num_rows;
                r_kernel       <= cfg_kernel_size;
                r_col          <= {C_COL_W{1'b0}};
                r_wr_row       <= {C_ROW_W{1'b0}};
                r_rows_written <= 10'd0;
            end else if (w_accept) begin
                r_col <= w_col_last ? {C_COL_W{1'b0}} : (r_col + C_COL_W'(1'b1));
                if (w_col_last) begin
                    r_wr_row       <= (r_wr_row == C_ROW_W'(C_RING_ROWS - 1))
                                      ? {C_ROW_W{1'b0}} : (r_wr_row + C_ROW_W'(1'b1));
                    r_rows_written <= r_rows_written + 10'd1;
                end
            end
        end
    end

    // Status outputs registered from next-state values so they line up
    // with the state they describe; ready drops as soon as the ring is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pixel_ready  <= 1'b0;
            r_window_ready <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_pixel_ready  <= (w_state_nxt == S_FILL)
                           && (32'(w_rows_avail_nxt) < 32'(C_RING_ROWS));
            r_window_ready <= ((w_state_nxt == S_FILL) || (w_state_nxt == S_DRAIN))
                           && (32'(w_rows_avail_nxt) >= 32'(w_kernel_nxt));
            r_busy         <= (w_state_nxt != S_IDLE);
            r_done         <= (w_state_nxt == S_DONE);
        end
    end

    // Row-buffer write port: accepted beat goes out one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_wr_en   <= 1'b0;
            r_buf_wr_row  <= {C_ROW_W{1'b0}};
            r_buf_wr_col  <= {C_COL_W{1'b0}};
            r_buf_wr_data <= {C_BEAT_WIDTH{1'b0}};
        end else begin
            r_buf_wr_en <= w_accept;
            if (w_accept) begin
                r_buf_wr_row <= r_wr_row;
                r_buf_wr_col <= r_col;
                for (int i = 0; i < C_PIXELS; i++) begin
                    r_buf_wr_data[i*C_PIXEL_WIDTH +: C_PIXEL_WIDTH] <=
                        pixel_data[i*C_PIXEL_WIDTH +: C_PIXEL_WIDTH];
                end
            end
        end
    end

    assign pixel_ready  = r_pixel_ready;
    assign buf_wr_en    = r_buf_wr_en;
    assign buf_wr_row   = r_buf_wr_row;
    assign buf_wr_col   = r_buf_wr_col;
    assign buf_wr_data  = r_buf_wr_data;
    assign rows_avail   = r_rows_avail;
    assign window_ready = r_window_ready;
    assign release_err  = r_release_err;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_cnn_layer_accel_pixel_ingest.sv
// ---------------------------------------------------------------------------
// Self-checking bench for cnn_layer_accel_pixel_ingest (default parameters).
// Each accepted beat pushes its expected {row, col, data} onto a queue; a
// negedge monitor pops and compares whenever the DUT writes a beat.
// ---------------------------------------------------------------------------
module tb_cnn_layer_accel_pixel_ingest;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_valid;
    logic [6:0]   cfg_row_beats;
    logic [9:0]   cfg_num_rows;
    logic [3:0]   cfg_kernel_size;
    logic         pixel_valid;
    logic         pixel_ready;
    logic [127:0] pixel_data;
    logic         buf_wr_en;
    logic [1:0]   buf_wr_row;
    logic [5:0]   buf_wr_col;
    logic [127:0] buf_wr_data;
    logic         row_release;
    logic [2:0]   rows_avail;
    logic         window_ready;
    logic         release_err;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;
    int n_writes = 0;
    int nacc     = 0;
    int m_col    = 0;
    int m_row    = 0;
    int m_beats  = 1;
    logic [127:0] cur_data;
    logic [135:0] sb_q[$];
    logic [135:0] sb_exp;

    cnn_layer_accel_pixel_ingest dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid),
        .cfg_row_beats(cfg_row_beats), .cfg_num_rows(cfg_num_rows),
        .cfg_kernel_size(cfg_kernel_size), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .pixel_data(pixel_data),
        .buf_wr_en(buf_wr_en), .buf_wr_row(buf_wr_row), .buf_wr_col(buf_wr_col),
        .buf_wr_data(buf_wr_data), .row_release(row_release),
        .rows_avail(rows_avail), .window_ready(window_ready),
        .release_err(release_err), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every write must match the oldest expected beat.
    always @(negedge clk) begin
        if (buf_wr_en === 1'b1) begin
            checks++;
            n_writes++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected: got row=%0d col=%0d, expected no write", buf_wr_row, buf_wr_col);
            end else begin
                sb_exp = sb_q.pop_front();
                if ({buf_wr_row, buf_wr_col, buf_wr_data} !== sb_exp) begin
                    failures++;
                    $display("FAIL wr_beat: got row=%0d col=%0d data=%h, expected row=%0d col=%0d data=%h",
                             buf_wr_row, buf_wr_col, buf_wr_data, sb_exp[135:134], sb_exp[133:128], sb_exp[127:0]);
                end
            end
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    // Drive one cycle of inputs; when the beat will be taken, record the expectation.
    task automatic drive(input logic v, input logic [127:0] d, input logic rel);
        cfg_valid   = 1'b0;
        pixel_valid = v;
        pixel_data  = d;
        row_release = rel;
        if (v && (pixel_ready === 1'b1) && !rst) begin
            sb_q.push_back({2'(m_row), 6'(m_col), d});
            m_col++;
            if (m_col == m_beats) begin
                m_col = 0;
                m_row = (m_row + 1) % 4;
            end
            nacc++;
            cur_data = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic send_cfg(input int rows, input int beats, input int kern);
        tick;
        cfg_valid       = 1'b1;
        cfg_num_rows    = 10'(rows);
        cfg_row_beats   = 7'(beats);
        cfg_kernel_size = 4'(kern);
        pixel_valid     = 1'b0;
        row_release     = 1'b0;
        m_col   = 0;
        m_row   = 0;
        m_beats = beats;
    endtask

    task automatic do_reset;
        tick;
        rst = 1'b1;
        drive(1'b0, cur_data, 1'b0);
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b0, cur_data, 1'b0);
        tick;
        tick;
        checks++; if (pixel_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b, expected 0", pixel_ready); end
        checks++; if (buf_wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en: got %b, expected 0", buf_wr_en); end
        checks++; if ({buf_wr_row, buf_wr_col} !== 8'd0) begin failures++; $display("FAIL rst_wr_addr: got %h, expected 0", {buf_wr_row, buf_wr_col}); end
        checks++; if (buf_wr_data !== 128'd0) begin failures++; $display("FAIL rst_wr_data: got %h, expected 0", buf_wr_data); end
        checks++; if (rows_avail !== 3'd0) begin failures++; $display("FAIL rst_rows_avail: got %0d, expected 0", rows_avail); end
        checks++; if ({window_ready, release_err, busy, done} !== 4'd0) begin failures++; $display("FAIL rst_status: got %b, expected 0000", {window_ready, release_err, busy, done}); end
        rst = 1'b0;
        tick;
        checks++; if ({busy, pixel_ready} !== 2'b00) begin failures++; $display("FAIL idle_after_rst: got busy/ready=%b, expected 00", {busy, pixel_ready}); end
    endtask

    // rows=5, beats=3, kernel=3: releases start once a window exists.
    task automatic test_basic_job;
        int  base   = nacc;
        int  wbase  = n_writes;
        int  gap    = 0;
        bit  saw_win = 1'b0;
        bit  fin    = 1'b0;
        bit  ok_done = 1'b0;
        logic rel;
        send_cfg(5, 3, 3);
        for (int c = 0; c < 300; c++) begin
            tick;
            if (fin) begin
                checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done_pulse: got %b, expected 1", done); end
                tick;
                checks++; if ({done, busy} !== 2'b00) begin failures++; $display("FAIL basic_done_end: got done/busy=%b, expected 00", {done, busy}); end
                ok_done = 1'b1;
                break;
            end
            if (done === 1'b1) begin
                checks++; failures++;
                $display("FAIL basic_early_done: got done=1 at beat %0d, expected 0", nacc - base);
                break;
            end
            if (window_ready === 1'b1 && !saw_win) begin
                saw_win = 1'b1;
                checks++;
                if (!(buf_wr_en === 1'b1 && buf_wr_row === 2'd2 && buf_wr_col === 6'd2)) begin
                    failures++;
                    $display("FAIL basic_window_first: got wr_en=%b row=%0d col=%0d, expected 1 row 2 col 2", buf_wr_en, buf_wr_row, buf_wr_col);
                end
            end
            rel = 1'b0;
            if (saw_win && gap >= 2 && rows_avail !== 3'd0) begin
                rel = 1'b1;
                gap = 0;
            end else begin
                gap++;
            end
            if (rel && (nacc - base) == 15 && rows_avail === 3'd1) fin = 1'b1;
            drive((nacc - base) < 15, cur_data, rel);
        end
        drive(1'b0, cur_data, 1'b0);
        checks++; if (!ok_done) begin failures++; $display("FAIL basic_completion: got done seen=%0d, expected 1", ok_done); end
        checks++; if (n_writes - wbase != 15) begin failures++; $display("FAIL basic_write_count: got %0d, expected 15", n_writes - wbase); end
    endtask

    // rows=8, beats=2, no release: ring fills after 8 beats; one release lets 2 more in.
    task automatic test_backpressure;
        int base = nacc;
        send_cfg(8, 2, 2);
        for (int c = 0; c < 40; c++) begin
            tick;
            drive(1'b1, cur_data, 1'b0);
        end
        tick;
        checks++; if (nacc - base != 8) begin failures++; $display("FAIL bp_accepted: got %0d, expected 8", nacc - base); end
        checks++; if (rows_avail !== 3'd4) begin failures++; $display("FAIL bp_rows_full: got %0d, expected 4", rows_avail); end
        checks++; if ({pixel_ready, window_ready, busy} !== 3'b011) begin failures++; $display("FAIL bp_flags: got ready/win/busy=%b, expected 011", {pixel_ready, window_ready, busy}); end
        drive(1'b1, cur_data, 1'b1);
        tick;
        checks++; if (rows_avail !== 3'd3) begin failures++; $display("FAIL bp_after_release: got %0d, expected 3", rows_avail); end
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, cur_data, 1'b0);
            tick;
            if (buf_wr_en === 1'b1) begin
                checks++; if (buf_wr_row !== 2'd0) begin failures++; $display("FAIL bp_slot: got row %0d, expected 0", buf_wr_row); end
            end
        end
        checks++; if (nacc - base != 10) begin failures++; $display("FAIL bp_extra_beats: got %0d total, expected 10", nacc - base); end
        checks++; if ({rows_avail, pixel_ready} !== {3'd4, 1'b0}) begin failures++; $display("FAIL bp_refull: got avail=%0d ready=%b, expected 4 0", rows_avail, pixel_ready); end
        do_reset;
    endtask

    // Commit of row 2 coincides with a release while two rows are held.
    task automatic test_commit_release;
        bit did = 1'b0;
        send_cfg(4, 2, 1);
        for (int c = 0; c < 40; c++) begin
            tick;
            if (rows_avail === 3'd2 && m_col == 1 && pixel_ready === 1'b1) begin
                drive(1'b1, cur_data, 1'b1);
                did = 1'b1;
                tick;
                checks++; if (rows_avail !== 3'd2) begin failures++; $display("FAIL cr_rows_avail: got %0d, expected 2", rows_avail); end
                checks++; if ({buf_wr_en, buf_wr_col} !== {1'b1, 6'd1}) begin failures++; $display("FAIL cr_commit_write: got en=%b col=%0d, expected 1 1", buf_wr_en, buf_wr_col); end
                break;
            end
            drive(1'b1, cur_data, 1'b0);
        end
        checks++; if (!did) begin failures++; $display("FAIL cr_reached: got %0d, expected 1", did); end
        drive(1'b0, cur_data, 1'b0);
        do_reset;
    endtask

    // Release with nothing held: sticky error, occupancy and FSM untouched.
    task automatic test_release_err;
        send_cfg(3, 3, 1);
        tick;
        drive(1'b0, cur_data, 1'b1);
        tick;
        checks++; if (release_err !== 1'b1) begin failures++; $display("FAIL err_set: got %b, expected 1", release_err); end
        checks++; if (rows_avail !== 3'd0) begin failures++; $display("FAIL err_rows_avail: got %0d, expected 0", rows_avail); end
        checks++; if ({busy, pixel_ready} !== 2'b11) begin failures++; $display("FAIL err_fsm: got busy/ready=%b, expected 11", {busy, pixel_ready}); end
        drive(1'b1, cur_data, 1'b0);
        tick;
        drive(1'b0, cur_data, 1'b0);
        tick;
        checks++; if (release_err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b, expected 1", release_err); end
    endtask

    // Continues the job above: reset while beat 1 of 3 is offered.
    task automatic test_reset_mid_row;
        int base;
        bit got_done = 1'b0;
        rst = 1'b1;
        drive(1'b1, cur_data, 1'b0);
        tick;
        checks++; if ({pixel_ready, buf_wr_en, buf_wr_row, buf_wr_col, rows_avail} !== 13'd0) begin failures++; $display("FAIL mid_rst_ctrl: got %h, expected 0", {pixel_ready, buf_wr_en, buf_wr_row, buf_wr_col, rows_avail}); end
        checks++; if (buf_wr_data !== 128'd0) begin failures++; $display("FAIL mid_rst_data: got %h, expected 0", buf_wr_data); end
        checks++; if ({window_ready, release_err, busy, done} !== 4'd0) begin failures++; $display("FAIL mid_rst_status: got %b, expected 0000", {window_ready, release_err, busy, done}); end
        rst = 1'b0;
        drive(1'b0, cur_data, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick;
            checks++; if ({done, buf_wr_en, busy} !== 3'b000) begin failures++; $display("FAIL mid_rst_quiet: got done/wr/busy=%b, expected 000", {done, buf_wr_en, busy}); end
        end
        send_cfg(2, 3, 1);
        tick;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_rst_newcfg: got busy=%b, expected 1", busy); end
        base = nacc;
        drive(1'b1, cur_data, 1'b0);
        tick;
        checks++; if ({buf_wr_en, buf_wr_row, buf_wr_col} !== {1'b1, 2'd0, 6'd0}) begin failures++; $display("FAIL mid_rst_first_wr: got en=%b row=%0d col=%0d, expected 1 0 0", buf_wr_en, buf_wr_row, buf_wr_col); end
        for (int c = 0; c < 60; c++) begin
            if (done === 1'b1) begin
                got_done = 1'b1;
                break;
            end
            drive((nacc - base) < 6, cur_data, rows_avail !== 3'd0);
            tick;
        end
        drive(1'b0, cur_data, 1'b0);
        checks++; if (!got_done) begin failures++; $display("FAIL mid_rst_job_done: got %0d, expected 1", got_done); end
        checks++; if (release_err !== 1'b0) begin failures++; $display("FAIL mid_rst_err_clear: got %b, expected 0", release_err); end
    endtask

    // Out-of-range configurations leave the block idle.
    task automatic test_bad_cfg;
        send_cfg(2, 3, 5);
        tick;
        drive(1'b1, cur_data, 1'b0);
        tick;
        checks++; if ({busy, pixel_ready} !== 2'b00) begin failures++; $display("FAIL badcfg_kernel: got busy/ready=%b, expected 00", {busy, pixel_ready}); end
        send_cfg(2, 0, 1);
        tick;
        drive(1'b1, cur_data, 1'b0);
        tick;
        checks++; if ({busy, pixel_ready, buf_wr_en} !== 3'b000) begin failures++; $display("FAIL badcfg_beats: got busy/ready/wr=%b, expected 000", {busy, pixel_ready, buf_wr_en}); end
        drive(1'b0, cur_data, 1'b0);
    endtask

    initial begin
        rst             = 1'b1;
        cfg_valid       = 1'b0;
        cfg_row_beats   = 7'd0;
        cfg_num_rows    = 10'd0;
        cfg_kernel_size = 4'd0;
        pixel_valid     = 1'b0;
        pixel_data      = 128'd0;
        row_release     = 1'b0;
        cur_data        = {$urandom, $urandom, $urandom, $urandom};
        test_reset;
        test_basic_job;
        test_backpressure;
        test_commit_release;
        test_release_err;
        test_reset_mid_row;
        test_bad_cfg;
        tick;
        tick;
        checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL sb_leftover: got %0d pending beats, expected 0", sb_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cnn_layer_accel_pixel_ingest.md
CNN_LAYER_ACCEL_PIXEL_INGEST -- requirements
Module: cnn_layer_accel_pixel_ingest

Interface
REQ-001 SHALL have parameter C_PIXEL_WIDTH, default 16: bits per pixel.
REQ-002 SHALL have parameter C_BEAT_WIDTH, default 128: pixel_data width, i.e. 8 pixels per beat.
REQ-003 SHALL have parameter C_RING_ROWS, default 4: row-buffer ring depth in rows.
REQ-004 SHALL have parameter C_MAX_BEATS, default 64: maximum beats per row.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports as follows.
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- cfg_valid  in  1  job configuration strobe.
- cfg_row_beats  in  7  beats per input row, 1..C_MAX_BEATS.
- cfg_num_rows  in  10  input rows per job, 1..1023.
- cfg_kernel_size  in  4  rows needed per window, 1..C_RING_ROWS.
- pixel_valid  in  1  input beat valid.
- pixel_ready  out  1  input beat accepted when valid and ready are both high.
- pixel_data  in  128  8 pixels; pixel 0 in bits [15:0].
- buf_wr_en  out  1  row-buffer write strobe.
- buf_wr_row  out  clog2(C_RING_ROWS)  ring slot written.
- buf_wr_col  out  6  beat index within the row.
- buf_wr_data  out  128  write data.
- row_release  in  1  consumer frees the oldest committed row.
- rows_avail  out  clog2(C_RING_ROWS)+1  committed rows held.
- window_ready  out  1  enough rows for one kernel window.
- release_err  out  1  sticky: release seen while rows_avail==0.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.

Function
REQ-006 SHALL implement the FSM states IDLE, FILL, DRAIN and DONE.
REQ-007 In IDLE, cfg_valid with all cfg fields in range SHALL latch the fields, clear the counters and move to FILL next cycle.
- Out-of-range cfg SHALL be ignored, with the FSM staying in IDLE.
- cfg_valid SHALL be ignored outside IDLE.
REQ-008 pixel_ready SHALL be high only in FILL with rows_avail < C_RING_ROWS, and SHALL be driven from registered state only.
REQ-009 An accepted beat SHALL appear on buf_wr_en/row/col/data exactly 1 cycle later, with buf_wr_en high for 1 cycle per beat.
REQ-010 The column counter SHALL increment per accepted beat and wrap to 0 after beat cfg_row_beats-1; that final beat commits the row.
REQ-011 On row commit:
- the write row SHALL advance modulo C_RING_ROWS;
- rows_avail SHALL increment in the same cycle the final beat is written;
- rows_written SHALL increment.
REQ-012 When rows_written reaches cfg_num_rows, the FSM SHALL go to DRAIN, with pixel_ready low from the cycle after the last accepted beat.
REQ-013 row_release with rows_avail>0 SHALL decrement rows_avail by 1.
- With rows_avail==0 it SHALL be ignored and SHALL set release_err.
REQ-014 Commit and release in the same cycle SHALL leave rows_avail unchanged.
REQ-015 window_ready SHALL be high in FILL or DRAIN when rows_avail >= cfg_kernel_size, and low otherwise.
REQ-016 In DRAIN, when rows_avail reaches 0 the FSM SHALL go to DONE.
- DONE SHALL assert done for exactly 1 cycle, then return to IDLE.
REQ-017 busy SHALL be high in FILL, DRAIN and DONE.
REQ-018 Beats presented while pixel_ready is low SHALL NOT be written, and SHALL NOT be lost from the source's view (standard valid/ready hold).
REQ-019 rows_avail SHALL never exceed C_RING_ROWS; no write SHALL target a slot holding an unreleased committed row.

Reset
REQ-020 rst SHALL force the FSM to IDLE within 1 cycle and clear all outputs: pixel_ready, buf_wr_en, buf_wr_row, buf_wr_col, buf_wr_data, rows_avail, window_ready, release_err, busy and done all read 0.
REQ-021 rst mid-job SHALL abandon the job with no further buf_wr_en and no done pulse; release_err SHALL clear only on rst.

Verification
REQ-022 The bench SHALL cover:
- cfg rows=5, beats=3, kernel=3, releasing one row per 3 beats -> 15 writes with cols 0,1,2 repeating and rows 0,1,2,3,0; window_ready first high the cycle row 2 commits; done 1 cycle after the final release.
- cfg rows=8, beats=2, no release -> pixel_ready low after 8 beats (rows_avail=4); 1 release -> exactly 2 more beats accepted, written to slot 0.
- Commit and release in the same cycle at rows_avail=2 -> rows_avail stays 2.
- Release at rows_avail=0 -> release_err=1, rows_avail stays 0, FSM unaffected.
- rst asserted mid-row (beat 1 of 3) -> all outputs 0 next cycle; a new cfg is accepted and writes start at row 0, col 0.
- cfg_kernel_size=5 with C_RING_ROWS=4, or cfg_row_beats=0 -> cfg ignored, busy stays 0.
